// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational instruction
// memory into a 2-entry FIFO and hands instructions to decode over valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned AWIDTH = 6,
    parameter int unsigned RWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_addr,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [RWIDTH-1:0] imem_data,
    output logic              inst_valid,
    output logic [RWIDTH-1:0] inst_data,
    output logic [AWIDTH-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [1:0]        fetch_state,
    output logic [15:0]       inst_count
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [RWIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [AWIDTH-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
    logic [CW-1:0]     icount_q, icount_d;
    logic              pop, fetch;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            e0_data_q <= '0;
            e0_pc_q   <= '0;
            e1_data_q <= '0;
            e1_pc_q   <= '0;
            icount_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            e0_data_q <= e0_data_d;
            e0_pc_q   <= e0_pc_d;
            e1_data_q <= e1_data_d;
            e1_pc_q   <= e1_pc_d;
            icount_q  <= icount_d;
        end
    end

    // Next-state: FIFO (entry 0 is the head), PC, counter and observational FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        e0_data_d = e0_data_q;
        e0_pc_d   = e0_pc_q;
        e1_data_d = e1_data_q;
        e1_pc_d   = e1_pc_q;
        icount_d  = icount_q;

        pop   = valid_q & inst_ready;
        fetch = run & ~redirect_valid & ((cnt_q != 2'd2) | pop);

        if (pop && (icount_q != {CW{1'b1}})) begin
            icount_d = icount_q + CW'(1);
        end

        if (redirect_valid) begin
            cnt_d = 2'd0;
            pc_d  = redirect_addr;
        end else begin
            if (fetch) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            case ({pop, fetch})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_data_d = e1_data_q;
                        e0_pc_d   = e1_pc_q;
                        e1_data_d = imem_data;
                        e1_pc_d   = pc_q;
                    end else begin
                        e0_data_d = imem_data;
                        e0_pc_d   = pc_q;
                    end
                end
                2'b10: begin
                    // A lone entry stays in place so the outputs hold their last value
                    if (cnt_q == 2'd2) begin
                        e0_data_d = e1_data_q;
                        e0_pc_d   = e1_pc_q;
                    end
                    cnt_d = cnt_q - 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        e0_data_d = imem_data;
                        e0_pc_d   = pc_q;
                    end else begin
                        e1_data_d = imem_data;
                        e1_pc_d   = pc_q;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end

        valid_d = (cnt_d != 2'd0);

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (!run)                                  state_d = IDLE;
                else if ((cnt_d == 2'd2) && !redirect_valid) state_d = FULL;
            end
            FULL: begin
                if (pop || redirect_valid) state_d = run ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst_data   = e0_data_q;
    assign inst_pc     = e0_pc_q;
    assign fetch_state = state_q;
    assign inst_count  = icount_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer for the 64-word, 32-bit combinational instruction memory: owns the program counter, drives the memory address, captures each returned word with its address into a 2-entry fetch buffer, and presents instructions to decode over a valid/ready handshake. It sits between `Instruction_Memory_32bit` and the decode stage. It supports run/stop control, branch redirect with buffer flush, and a saturating count of delivered instructions.

## Interface
- `AWIDTH`, 6: instruction address width in words; memory depth is 2**AWIDTH.
- `RWIDTH`, 32: instruction word width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `run`  in  1  fetch enable; when 0, no new fetches are issued.
- `redirect_valid`  in  1  branch/jump redirect request, single-cycle pulse.
- `redirect_addr`  in  AWIDTH  new PC for redirect.
- `imem_addr`  out  AWIDTH  address to instruction memory; equals the PC register.
- `imem_data`  in  RWIDTH  combinational read data from instruction memory.
- `inst_valid`  out  1  buffer head holds a valid instruction.
- `inst_data`  out  RWIDTH  instruction at buffer head.
- `inst_pc`  out  AWIDTH  address of `inst_data`.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `fetch_state`  out  2  FSM state: 0 IDLE, 1 FETCH, 2 FULL.
- `inst_count`  out  16  number of completed handshakes, saturating at 16'hFFFF.

## Operation
- Reset (`rst_n`=0 at an edge): PC=0, buffer count=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `imem_addr`=0, `fetch_state`=IDLE, `inst_count`=0. Reset mid-operation discards buffer contents and the PC immediately.
- Pop: `inst_valid`=1 and `inst_ready`=1 in the same cycle. Each pop increments `inst_count` unless it is at 16'hFFFF.
- Fetch condition in a cycle: `run`=1, `redirect_valid`=0, and (count<2 or pop this cycle).
- Fetch action: at the edge, push {PC, `imem_data`} into the buffer and set PC=PC+1 modulo 2**AWIDTH. The PC wraps from 63 to 0 with no stall.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO).
- Redirect (`redirect_valid`=1): has priority over fetch.
  - A pop in the same cycle still completes and is counted.
  - All remaining buffer entries are discarded, so count=0.
  - PC=`redirect_addr`; no push that cycle.
  - Redirect is honoured regardless of `run`.
- `run`=0: no pushes; the buffer continues to drain via pops.
- `inst_data`/`inst_pc` are meaningful only while `inst_valid`=1; they hold their last value otherwise.
- FSM, registered and evaluated from next-cycle conditions:
  - IDLE: `run`=0 → IDLE; `run`=1 → FETCH.
  - FETCH: `run`=0 → IDLE; next count=2 with no redirect → FULL.
  - FULL: pop or redirect → FETCH (IDLE if `run`=0); otherwise FULL.
  - The state is observational only; the fetch condition above is authoritative.

## Timing
- Memory read is combinational, so a fetch completes in one cycle.
- Fetch latency: a word fetched in cycle N is visible with `inst_valid`=1 in cycle N+1.
- First fetch after reset release with `run`=1: address 0 is fetched in cycle 0; `inst_valid`=1 with `inst_pc`=0 in cycle 1.
- Redirect asserted in cycle N: `imem_addr`=`redirect_addr` in cycle N+1; that instruction is valid in cycle N+2. Two-cycle bubble.
- Sustained throughput: with `inst_ready` held at 1, one instruction per cycle.
- Back-pressure: with `inst_ready`=0, the buffer fills to 2 and PC stops advancing; the head is held stable until popped.

## Test plan
- **Reset and streaming:** hold `rst_n`=0 for 2 cycles, then `run`=1 and `inst_ready`=1 for 70 cycles.
  - `inst_pc` must read 0,1,...,63,0,1,... one per cycle, starting in cycle 1.
  - `inst_data` must match memory contents.
  - `inst_count`=69 at the end.
- **Back-pressure:** run with `inst_ready`=0.
  - Buffer holds pc 0 and 1; `imem_addr` stays at 2; `fetch_state`=FULL.
  - Release `inst_ready`: pcs 0,1,2,... are delivered in order with no gap or duplicate.
- **Redirect:** in the cycle `inst_pc`=5 is popped, pulse `redirect_valid` with `redirect_addr`=40.
  - The pc 5 pop is counted; pc 6 is discarded.
  - Next valid `inst_pc`=40, two cycles later.
- **Redirect while full and stopped:** fill the buffer, set `run`=0, then redirect to 10.
  - `inst_valid`=0 and no fetch occurs.
  - Set `run`=1: `inst_pc`=10 is delivered.
- **Mid-operation reset:** assert `rst_n`=0 while the buffer is full at PC 30.
  - Next cycle: all outputs are at their reset values; after release, fetch restarts at 0.
- **Counter saturation:** preload or run more than 65535 pops; `inst_count` must stay at 16'hFFFF.
